pe_config_sequencer: RTL and testbench
======================================

# pe_config_sequencer

Config-table-driven issue controller for one PE column of the SIMD datapath. Holds up to 256 programmed operation entries, and on `start` walks them in order. For each entry it streams register-file read addresses and the 2-bit `op` code into the PE column, then generates the matching write-back strobe/address exactly one PE latency later. Sits between the host-loaded configuration path and the PE column's `data_channel`/`control_channel` pair.

## Interface
- `DEPTH_CFG`, 256, config table depth (max_depth_config_table)
- `CFG_AW`, 8, `$clog2(DEPTH_CFG)`
- `RF_AW`, 12, RF address width (`$clog2(depth_RF)`, depth_RF = 4096)
- `LAT_A` / `LAT_B` / `LAT_C` / `LAT_D`, 6 / 4 / 12 / 57, PE latency for op = 0 / 1 / 2 / 3
- `ENTRY_W`, 50, entry width: {op[49:48], src1[47:36], src2[35:24], dst[23:12], len[11:0]}

Ports:
- `ap_clk`  in  1  clock
- `ap_rst_n`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  table write strobe
- `cfg_waddr`  in  CFG_AW  table write address
- `cfg_wdata`  in  ENTRY_W  table write data
- `num_entries`  in  CFG_AW+1  entries to execute (0..256), sampled on accepted `start`
- `start`  in  1  run request pulse
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle completion pulse
- `issue_ready`  in  1  PE column can accept an element this cycle
- `rd_en`  out  1  element issued this cycle
- `rd_addr1`, `rd_addr2`  out  RF_AW  RF read addresses feeding inp1/inp2
- `op`  out  2  control_channel op for the issued element
- `wb_en`  out  1  out1 result valid, write to RF
- `wb_addr`  out  RF_AW  RF write address

## Operation
- FSM states: IDLE, FETCH, ISSUE, DRAIN_SW, DRAIN_END, DONE.
- IDLE: `start` accepted only here. It latches `num_entries` and clears the entry index, then moves to FETCH. If `num_entries` = 0, it goes directly to DRAIN_END.
- FETCH: presents the table read address. The synchronous read returns the entry, which is registered into cur_op/src1/src2/dst/remaining. Next state is chosen as follows:
  - len = 0: entry skipped; index increments, then FETCH again or DRAIN_END.
  - LAT(cur_op) < LAT(previous issued op) and tracker non-empty: DRAIN_SW.
  - Otherwise: ISSUE.
- DRAIN_SW: waits until the tracker is empty, then goes to ISSUE. This guarantees writebacks are in order and never collide on `wb_en`.
- ISSUE: `rd_en` = `issue_ready`. On each issue:
  - src1/src2/dst each increment by 1, modulo 4096 (wrap 4095→0).
  - remaining decrements.
  - The tracker inserts (dst) at slot LAT(cur_op)-1.
  - After the last element: FETCH for the next entry, or DRAIN_END after entry num_entries-1.
- Tracker: LAT_D-deep shift register of {valid, addr}, shifting toward slot 0 every cycle. Slot 0 drives `wb_en`/`wb_addr`.
- DRAIN_END: waits until the tracker is empty, then goes to DONE.
- DONE: `done` = 1 for one cycle, then IDLE. `busy` is 1 in every state except IDLE and DONE.
- Config writes:
  - Accepted only while `busy` = 0; writes while busy are dropped.
  - Table contents are not reset.
- `start` while busy is ignored.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wb_en` = 0; `rd_addr1`, `rd_addr2`, `wb_addr` = 0; `op` = 0. Tracker cleared, FSM = IDLE.
- Reset mid-run aborts immediately and all in-flight writebacks are lost. No `done` is generated.
- `start` sampled at cycle 0. FETCH is in cycle 1. The first `rd_en` is in cycle 2 at the earliest.
- `rd_addr*`/`op` are registered and valid in the same cycle as `rd_en`.
- Element issued in cycle t produces `wb_en` in cycle t+LAT(op), with `wb_addr` = that element's dst.
- Entry-to-entry overhead: one FETCH bubble, plus a drain when latency decreases.
- `issue_ready` low holds the address registers, with `rd_en` = 0. The tracker keeps shifting.
- `done` occurs in the cycle after the last `wb_en`. For `num_entries` = 0, `done` occurs at cycle 2.

## Test plan
- Load entry 0 = {op 0, src1 0x010, src2 0x020, dst 0x030, len 4}, num_entries 1, `issue_ready` held 1.
  - `rd_en` in cycles 2–5 with rd_addr1 0x010–0x013.
  - `wb_en` in cycles 8–11 with wb_addr 0x030–0x033.
  - `done` in cycle 12.
- Two entries: op 3 (len 2) then op 1 (len 2).
  - Second entry's first `rd_en` is delayed until the tracker is empty.
  - Four `wb_en` pulses, never two in one cycle, addresses in order.
- Wrap-around: src1 0xFFE, len 4 → rd_addr1 sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Backpressure: len 3, `issue_ready` low in cycle 3 only.
  - `rd_en` in cycles 2, 4, 5.
  - Each `wb_en` exactly LAT after its issue cycle.
- Corner cases:
  - `num_entries` = 0 → `done` at cycle 2, no `rd_en`/`wb_en`.
  - A len-0 entry is skipped.
  - `start` and `cfg_we` while busy have no effect.
- Assert `ap_rst_n` low mid-ISSUE with writebacks in flight.
  - All outputs go to 0 immediately.
  - No `wb_en` and no `done` follow until a new `start`.

Source files
------------

// File: rtl/pe_config_sequencer.sv
// pe_config_sequencer: walks a host-loaded table of PE operations, issuing
// register-file read addresses and op codes into one PE column, and emits
// the matching in-order writeback strobe/address after each op's latency.
module pe_config_sequencer #(
  parameter int unsigned DEPTH_CFG = 256,
  parameter int unsigned CFG_AW    = 8,
  parameter int unsigned RF_AW     = 12,
  parameter int unsigned LAT_A     = 6,
  parameter int unsigned LAT_B     = 4,
  parameter int unsigned LAT_C     = 12,
  parameter int unsigned LAT_D     = 57,
  parameter int unsigned ENTRY_W   = 50
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                cfg_we,
  input  logic [CFG_AW-1:0]   cfg_waddr,
  input  logic [ENTRY_W-1:0]  cfg_wdata,
  input  logic [CFG_AW:0]     num_entries,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                issue_ready,
  output logic                rd_en,
  output logic [RF_AW-1:0]    rd_addr1,
  output logic [RF_AW-1:0]    rd_addr2,
  output logic [1:0]          op,
  output logic                wb_en,
  output logic [RF_AW-1:0]    wb_addr
);

  localparam int unsigned LAT_W = $clog2(LAT_D + 1);
  localparam int unsigned IDX_W = CFG_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_DRAIN_SW, S_DRAIN_END, S_DONE
  } state_t;

  // PE pipeline latency for a given op code
  function automatic logic [LAT_W-1:0] lat_f(input logic [1:0] o);
    logic [LAT_W-1:0] l;
    case (o)
      2'd0:    l = LAT_W'(LAT_A);
      2'd1:    l = LAT_W'(LAT_B);
      2'd2:    l = LAT_W'(LAT_C);
      default: l = LAT_W'(LAT_D);
    endcase
    return l;
  endfunction

  state_t state, state_nxt;

  logic [ENTRY_W-1:0] mem [DEPTH_CFG];
  logic [ENTRY_W-1:0] mem_q;

  logic [IDX_W-1:0]  idx, idx_nxt, num_q;
  logic [1:0]        cur_op, prev_op;
  logic [RF_AW-1:0]  src1, src2, dst, rem;

  logic [LAT_D-1:0]  trk_v;
  logic [RF_AW-1:0]  trk_a [LAT_D];

  logic [1:0]        e_op;
  logic [RF_AW-1:0]  e_src1, e_src2, e_dst, e_len;
  logic [IDX_W-1:0]  idx_p1;
  logic              last_c, trk_busy_c, issue_c;
  logic [LAT_W-1:0]  ins_slot;

  assign e_op   = mem_q[ENTRY_W-1 -: 2];
  assign e_src1 = mem_q[4*RF_AW-1 -: RF_AW];
  assign e_src2 = mem_q[3*RF_AW-1 -: RF_AW];
  assign e_dst  = mem_q[2*RF_AW-1 -: RF_AW];
  assign e_len  = mem_q[RF_AW-1:0];

  assign idx_p1     = idx + IDX_W'(1);
  assign last_c     = (idx_p1 == num_q);
  // Slot 0 leaves this cycle, so only deeper slots hold back a state change
  assign trk_busy_c = |trk_v[LAT_D-1:1];
  assign issue_c    = (state == S_ISSUE) && issue_ready;
  assign ins_slot   = lat_f(cur_op) - LAT_W'(1);

  // Config table: host writes only while idle; read is prefetched one cycle ahead
  always_ff @(posedge ap_clk) begin
    if (cfg_we && !busy) mem[cfg_waddr] <= cfg_wdata;
    mem_q <= mem[idx_nxt[CFG_AW-1:0]];
  end

  // FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state and entry-index selection
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          state_nxt = (num_entries == '0) ? S_DRAIN_END : S_FETCH;
        end
      end
      S_FETCH: begin
        if (e_len == '0) begin
          idx_nxt   = idx_p1;
          state_nxt = last_c ? S_DRAIN_END : S_FETCH;
        end else if ((lat_f(e_op) < lat_f(prev_op)) && trk_busy_c) begin
          state_nxt = S_DRAIN_SW;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_DRAIN_SW: begin
        if (!trk_busy_c) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue_ready && (rem == RF_AW'(1))) begin
          idx_nxt   = idx_p1;
          state_nxt = last_c ? S_DRAIN_END : S_FETCH;
        end
      end
      S_DRAIN_END: begin
        if (!trk_busy_c) state_nxt = S_DONE;
      end
      S_DONE: begin
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy  = 1'b1;
    done  = 1'b0;
    rd_en = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_DONE:  begin busy = 1'b0; done = 1'b1; end
      S_ISSUE: rd_en = issue_ready;
      default: ;
    endcase
  end

  // Current-entry registers: loaded on fetch, stepped on each issued element
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idx     <= '0;
      num_q   <= '0;
      cur_op  <= '0;
      prev_op <= '0;
      src1    <= '0;
      src2    <= '0;
      dst     <= '0;
      rem     <= '0;
    end else begin
      idx <= idx_nxt;
      if ((state == S_IDLE) && start) num_q <= num_entries;
      if (state == S_FETCH) begin
        cur_op <= e_op;
        src1   <= e_src1;
        src2   <= e_src2;
        dst    <= e_dst;
        rem    <= e_len;
      end else if (issue_c) begin
        src1    <= src1 + RF_AW'(1);
        src2    <= src2 + RF_AW'(1);
        dst     <= dst + RF_AW'(1);
        rem     <= rem - RF_AW'(1);
        prev_op <= cur_op;
      end
    end
  end

  // Writeback tracker: shifts toward slot 0, new element lands at LAT-1
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      trk_v <= '0;
      for (int i = 0; i < LAT_D; i++) trk_a[i] <= '0;
    end else begin
      for (int i = 0; i < LAT_D - 1; i++) begin
        trk_v[i] <= trk_v[i+1];
        trk_a[i] <= trk_a[i+1];
      end
      trk_v[LAT_D-1] <= 1'b0;
      trk_a[LAT_D-1] <= '0;
      if (issue_c) begin
        trk_v[ins_slot] <= 1'b1;
        trk_a[ins_slot] <= dst;
      end
    end
  end

  assign rd_addr1 = src1;
  assign rd_addr2 = src2;
  assign op       = cur_op;
  assign wb_en    = trk_v[0];
  assign wb_addr  = trk_a[0];

endmodule

// File: tb/tb_pe_config_sequencer.sv
// Bench for pe_config_sequencer: directed table of runs, a reset-abort
// sequence, and randomized runs against a cycle-schedule reference model.
module tb_pe_config_sequencer;

  localparam int unsigned CFG_AW  = 8;
  localparam int unsigned RF_AW   = 12;
  localparam int unsigned ENTRY_W = 50;
  localparam int MAXC = 1024;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic               cfg_we;
  logic [CFG_AW-1:0]  cfg_waddr;
  logic [ENTRY_W-1:0] cfg_wdata;
  logic [CFG_AW:0]    num_entries;
  logic               start;
  logic               busy, done;
  logic               issue_ready;
  logic               rd_en;
  logic [RF_AW-1:0]   rd_addr1, rd_addr2;
  logic [1:0]         op;
  logic               wb_en;
  logic [RF_AW-1:0]   wb_addr;

  pe_config_sequencer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .num_entries(num_entries), .start(start), .busy(busy), .done(done),
    .issue_ready(issue_ready), .rd_en(rd_en), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .op(op), .wb_en(wb_en), .wb_addr(wb_addr)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [ENTRY_W-1:0] e0;
    logic [ENTRY_W-1:0] e1;
    int num;
    int stall;
    bit inj;
    int x_first_rd;
    int x_first_wb;
    int x_done;
    int x_nwb;
    int x_last_a1;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ENTRY_W-1:0] ent [4];
  bit                 rdy [MAXC];
  bit                 x_rd [MAXC];
  bit                 x_wb [MAXC];
  logic [11:0]        x_a1 [MAXC];
  logic [11:0]        x_a2 [MAXC];
  logic [11:0]        x_wa [MAXC];
  logic [1:0]         x_op [MAXC];
  int                 x_done;
  int m_first_rd, m_first_wb, m_done, m_nwb, m_last_a1;
  vec_t vecs [8];

  function automatic logic [ENTRY_W-1:0] mk(input logic [1:0] o, input logic [11:0] s1,
                                            input logic [11:0] s2, input logic [11:0] d,
                                            input logic [11:0] n);
    return {o, s1, s2, d, n};
  endfunction

  function automatic int lat_of(input logic [1:0] o);
    case (o)
      2'd0:    return 6;
      2'd1:    return 4;
      2'd2:    return 12;
      default: return 57;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference schedule: per-cycle expected issue/writeback events and done cycle.
  // Cycle 0 is the start cycle; the first entry is fetched in cycle 1.
  function automatic void build_model(input int num);
    int t, c, last_wb, prev_lat, lat, len, s1, s2, d;
    for (int i = 0; i < MAXC; i++) begin
      x_rd[i] = 1'b0; x_wb[i] = 1'b0;
      x_a1[i] = '0; x_a2[i] = '0; x_wa[i] = '0; x_op[i] = '0;
    end
    t = 1; last_wb = -1; prev_lat = 0;
    for (int k = 0; k < num; k++) begin
      lat = lat_of(ent[k][49:48]);
      len = int'(ent[k][11:0]);
      s1  = int'(ent[k][47:36]);
      s2  = int'(ent[k][35:24]);
      d   = int'(ent[k][23:12]);
      if (len == 0) begin
        t++;
      end else begin
        // a shorter-latency op must wait until every older writeback is out
        c = (lat < prev_lat && last_wb > t) ? last_wb + 1 : t + 1;
        for (int i = 0; i < len; i++) begin
          while (!rdy[c] && c < MAXC - 64) c++;
          x_rd[c] = 1'b1;
          x_a1[c] = 12'((s1 + i) % 4096);
          x_a2[c] = 12'((s2 + i) % 4096);
          x_op[c] = ent[k][49:48];
          x_wb[c + lat] = 1'b1;
          x_wa[c + lat] = 12'((d + i) % 4096);
          last_wb = c + lat;
          c++;
        end
        t = c;
        prev_lat = lat;
      end
    end
    x_done = ((t > last_wb) ? t : last_wb) + 1;
  endfunction

  task automatic cfg_write(input logic [7:0] a, input logic [ENTRY_W-1:0] d);
    @(negedge ap_clk);
    cfg_we = 1'b1; cfg_waddr = a; cfg_wdata = d;
    @(negedge ap_clk);
    cfg_we = 1'b0;
  endtask

  // One run: start in cycle 0, compare every cycle against the model
  task automatic run(input int num, input bit inj);
    logic [41:0] act, exp;
    build_model(num);
    m_first_rd = -1; m_first_wb = -1; m_done = -1; m_nwb = 0; m_last_a1 = -1;
    for (int c = 0; c <= x_done + 4; c++) begin
      @(negedge ap_clk);
      start       = (c == 0) || (inj && c == 2);
      num_entries = 9'(num);
      cfg_we      = inj && (c == 2);
      cfg_waddr   = 8'd1;
      cfg_wdata   = mk(2'd2, 12'hAAA, 12'hBBB, 12'hCCC, 12'd9);
      issue_ready = rdy[c];
      #1;
      act = {rd_en, rd_en ? rd_addr1 : 12'h0, rd_en ? rd_addr2 : 12'h0, rd_en ? op : 2'h0,
             wb_en, wb_en ? wb_addr : 12'h0, done, busy};
      exp = {x_rd[c], x_a1[c], x_a2[c], x_op[c], x_wb[c], x_wa[c],
             (c == x_done), (c >= 1 && c < x_done)};
      chk($sformatf("trace_cycle%0d", c), 64'(act), 64'(exp));
      if (rd_en) begin
        if (m_first_rd < 0) m_first_rd = c;
        m_last_a1 = int'(rd_addr1);
      end
      if (wb_en) begin
        if (m_first_wb < 0) m_first_wb = c;
        m_nwb++;
      end
      if (done && m_done < 0) m_done = c;
    end
    start = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    int quiet;
    int num;
    vecs[0] = '{mk(2'd0, 12'h010, 12'h020, 12'h030, 12'd4), '0, 1, -1, 1'b0, 2, 8, 12, 4, 'h013};
    vecs[1] = '{mk(2'd3, 12'h100, 12'h200, 12'h300, 12'd2),
                mk(2'd1, 12'h110, 12'h210, 12'h310, 12'd2), 2, -1, 1'b0, 2, 59, 67, 4, 'h111};
    vecs[2] = '{mk(2'd0, 12'hFFE, 12'h005, 12'hFFF, 12'd4), '0, 1, -1, 1'b0, 2, 8, 12, 4, 'h001};
    vecs[3] = '{mk(2'd2, 12'h040, 12'h050, 12'h060, 12'd3), '0, 1, 3, 1'b0, 2, 14, 18, 3, 'h042};
    vecs[4] = '{mk(2'd0, 12'h010, 12'h020, 12'h030, 12'd4), '0, 0, -1, 1'b0, -1, -1, 2, 0, -1};
    vecs[5] = '{mk(2'd1, 12'h0AA, 12'h0BB, 12'h0CC, 12'd0),
                mk(2'd0, 12'h070, 12'h080, 12'h090, 12'd2), 2, -1, 1'b0, 3, 9, 11, 2, 'h071};
    vecs[6] = '{mk(2'd0, 12'h010, 12'h020, 12'h030, 12'd2),
                mk(2'd0, 12'h050, 12'h060, 12'h070, 12'd2), 2, -1, 1'b1, 2, 8, 13, 4, 'h051};
    vecs[7] = '{mk(2'd1, 12'h200, 12'h210, 12'h220, 12'd2),
                mk(2'd2, 12'h300, 12'h310, 12'h320, 12'd1), 2, -1, 1'b0, 2, 6, 18, 3, 'h300};

    ap_rst_n = 1'b0; cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0;
    num_entries = '0; start = 1'b0; issue_ready = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("reset_outputs", 64'({busy, done, rd_en, rd_addr1, rd_addr2, op, wb_en, wb_addr}), 64'(0));
    ap_rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      ent[0] = vecs[v].e0; ent[1] = vecs[v].e1; ent[2] = '0; ent[3] = '0;
      cfg_write(8'd0, ent[0]);
      cfg_write(8'd1, ent[1]);
      for (int c = 0; c < MAXC; c++) rdy[c] = 1'b1;
      if (vecs[v].stall >= 0) rdy[vecs[v].stall] = 1'b0;
      run(vecs[v].num, vecs[v].inj);
      chki($sformatf("v%0d_first_rd", v), m_first_rd, vecs[v].x_first_rd);
      chki($sformatf("v%0d_first_wb", v), m_first_wb, vecs[v].x_first_wb);
      chki($sformatf("v%0d_done", v), m_done, vecs[v].x_done);
      chki($sformatf("v%0d_nwb", v), m_nwb, vecs[v].x_nwb);
      chki($sformatf("v%0d_last_a1", v), m_last_a1, vecs[v].x_last_a1);
    end

    // Reset mid-ISSUE with writebacks in flight
    cfg_write(8'd0, mk(2'd3, 12'h100, 12'h200, 12'h300, 12'd8));
    @(negedge ap_clk);
    start = 1'b1; num_entries = 9'd1; issue_ready = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    repeat (4) @(negedge ap_clk);
    #1;
    chk("pre_reset_rd_en", 64'(rd_en), 64'(1));
    #1 ap_rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs",
        64'({busy, done, rd_en, rd_addr1, rd_addr2, op, wb_en, wb_addr}), 64'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    quiet = 0;
    repeat (120) begin
      @(negedge ap_clk);
      #1;
      if (wb_en || done || busy || rd_en) quiet++;
    end
    chki("post_reset_quiet", quiet, 0);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++) begin
        ent[k] = mk(2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom), 12'($urandom),
                    12'($urandom_range(0, 6)));
        cfg_write(8'(k), ent[k]);
      end
      for (int c = 0; c < MAXC; c++)
        rdy[c] = (c < MAXC / 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      num = int'($urandom_range(0, 4));
      run(num, 1'b0);
      chki($sformatf("rand%0d_done", r), m_done, x_done);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
